// File: rtl/acc_reg_pkg.sv
// Shared types and constants for the accumulator register bank.
package acc_reg_pkg;

  // Copy engine states
  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} copy_state_t;

  // Register 0 is the accumulator
  localparam int unsigned ACC_IDX = 0;

endpackage

// File: rtl/acc_copy_fsm.sv
// Save/restore copy engine: walks every register index once per request and
// tells the bank which direction to copy. busy/done are decoded from the state
// register only, so they have no combinational path from the request inputs.
module acc_copy_fsm
  import acc_reg_pkg::*;
#(
  parameter int unsigned D = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         save_req_i,
  input  logic         restore_req_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         idle_o,
  output logic         copy_save_o,
  output logic         copy_restore_o,
  output logic [D-1:0] copy_idx_o
);

  // N = 2**D, so the last index is all ones and the counter never wraps
  localparam logic [D-1:0] LastIdx = {D{1'b1}};
  localparam logic [D-1:0] CntOne  = {{(D-1){1'b0}}, 1'b1};

  copy_state_t  state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; save wins when both requests arrive together
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (save_req_i) begin
          state_d = SAVE;
        end else if (restore_req_i) begin
          state_d = RESTORE;
        end
      end
      SAVE, RESTORE: begin
        cnt_d = cnt_q + CntOne;
        if (cnt_q == LastIdx) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    busy_o         = (state_q == SAVE) || (state_q == RESTORE);
    done_o         = (state_q == DONE);
    idle_o         = (state_q == IDLE);
    copy_save_o    = (state_q == SAVE);
    copy_restore_o = (state_q == RESTORE);
    copy_idx_o     = cnt_q;
  end

endmodule

// File: rtl/acc_reg_bank.sv
// Accumulator register file with two combinational read ports, dual write,
// optional write-to-read bypass and a shadow bank for context save/restore.
module acc_reg_bank
  import acc_reg_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned D      = 4,
  parameter bit          BYPASS = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         RegWrite,
  input  logic         AccWrite,
  input  logic [D-1:0] reg_index,
  input  logic [D-1:0] rd_index_b,
  input  logic [W-1:0] writeValue,
  input  logic         save_req,
  input  logic         restore_req,
  output logic [W-1:0] Acc_out,
  output logic [W-1:0] Reg_out,
  output logic [W-1:0] RegB_out,
  output logic         busy,
  output logic         done
);

  localparam int unsigned  N      = 2 ** D;
  localparam logic [D-1:0] AccIdx = D'(ACC_IDX);

  logic [W-1:0] live_q   [N];
  logic [W-1:0] live_d   [N];
  logic [W-1:0] shadow_q [N];
  logic [W-1:0] shadow_d [N];

  logic         idle;
  logic         copy_save;
  logic         copy_restore;
  logic [D-1:0] copy_idx;
  logic         acc_we;
  logic         reg_we;

  acc_copy_fsm #(
    .D (D)
  ) u_copy_fsm (
    .clk_i          (CLK),
    .rst_ni         (RST_N),
    .save_req_i     (save_req),
    .restore_req_i  (restore_req),
    .busy_o         (busy),
    .done_o         (done),
    .idle_o         (idle),
    .copy_save_o    (copy_save),
    .copy_restore_o (copy_restore),
    .copy_idx_o     (copy_idx)
  );

  // Core write enables; writes land only while the copy engine is idle.
  // A RegWrite to index 0 folds into the accumulator write.
  always_comb begin
    acc_we = idle && (AccWrite || (RegWrite && (reg_index == AccIdx)));
    reg_we = idle && RegWrite && (reg_index != AccIdx);
  end

  // Next contents of the live and shadow banks
  always_comb begin
    live_d   = live_q;
    shadow_d = shadow_q;
    if (acc_we) begin
      live_d[AccIdx] = writeValue;
    end
    if (reg_we) begin
      live_d[reg_index] = writeValue;
    end
    if (copy_save) begin
      shadow_d[copy_idx] = live_q[copy_idx];
    end
    if (copy_restore) begin
      live_d[copy_idx] = shadow_q[copy_idx];
    end
  end

  // Storage; reset clears both banks and discards any partial copy
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < N; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding
  always_comb begin
    Acc_out  = live_q[AccIdx];
    Reg_out  = live_q[reg_index];
    RegB_out = live_q[rd_index_b];
    if (BYPASS) begin
      if (acc_we) begin
        Acc_out = writeValue;
      end
      if (reg_we || (acc_we && (reg_index == AccIdx))) begin
        Reg_out = writeValue;
      end
      if ((reg_we && (rd_index_b == reg_index)) || (acc_we && (rd_index_b == AccIdx))) begin
        RegB_out = writeValue;
      end
    end
  end

endmodule

// File: tb/tb_acc_reg_bank.sv
// Self-checking bench for acc_reg_bank: a reference model of the live bank
// feeds a queue of expected register values that are popped and compared
// against the read port. A second instance with BYPASS=1 shares all inputs.
module tb_acc_reg_bank;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;
  localparam int unsigned N = 16;

  typedef struct {
    logic [D-1:0] idx;
    logic [W-1:0] val;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         RegWrite;
  logic         AccWrite;
  logic [D-1:0] reg_index;
  logic [D-1:0] rd_index_b;
  logic [W-1:0] writeValue;
  logic         save_req;
  logic         restore_req;

  logic [W-1:0] acc_out, reg_out, regb_out;
  logic         busy, done;
  logic [W-1:0] bp_acc_out, bp_reg_out, bp_regb_out;
  logic         bp_busy, bp_done;

  logic [W-1:0] model [N];
  logic [W-1:0] saved [N];
  exp_t         sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  acc_reg_bank #(.W(W), .D(D), .BYPASS(1'b0)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RegWrite    (RegWrite),
    .AccWrite    (AccWrite),
    .reg_index   (reg_index),
    .rd_index_b  (rd_index_b),
    .writeValue  (writeValue),
    .save_req    (save_req),
    .restore_req (restore_req),
    .Acc_out     (acc_out),
    .Reg_out     (reg_out),
    .RegB_out    (regb_out),
    .busy        (busy),
    .done        (done)
  );

  acc_reg_bank #(.W(W), .D(D), .BYPASS(1'b1)) dut_bp (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RegWrite    (RegWrite),
    .AccWrite    (AccWrite),
    .reg_index   (reg_index),
    .rd_index_b  (rd_index_b),
    .writeValue  (writeValue),
    .save_req    (save_req),
    .restore_req (restore_req),
    .Acc_out     (bp_acc_out),
    .Reg_out     (bp_reg_out),
    .RegB_out    (bp_regb_out),
    .busy        (bp_busy),
    .done        (bp_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [W-1:0] val);
    RegWrite   = 1'b1;
    reg_index  = D'(idx);
    writeValue = val;
    tick();
    RegWrite   = 1'b0;
    model[idx] = val;
  endtask

  task automatic push_all();
    for (int i = 0; i < N; i++) begin
      sb_q.push_back('{idx: D'(i), val: model[i]});
    end
  endtask

  // Pop every expected entry and compare against read port A
  task automatic drain(input string tag);
    exp_t e;
    RegWrite = 1'b0;
    AccWrite = 1'b0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      reg_index = e.idx;
      #1;
      check_val($sformatf("%s[%0d]", tag, e.idx), 32'(reg_out), 32'(e.val));
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      if (done) seen = 1'b1;
      tick();
    end
    if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) model[i] = '0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int first_done;
    int overlap;

    RST_N       = 1'b0;
    RegWrite    = 1'b0;
    AccWrite    = 1'b0;
    reg_index   = '0;
    rd_index_b  = '0;
    writeValue  = '0;
    save_req    = 1'b0;
    restore_req = 1'b0;
    clear_model();
    tick();
    tick();
    RST_N = 1'b1;

    // 1. Reset clears a previously written register
    write_reg(5, 8'hAA);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    clear_model();
    reg_index = 4'd5;
    #1;
    check_val("reset_reg5", 32'(reg_out), 32'h00);
    check_val("reset_acc", 32'(acc_out), 32'h00);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);

    // 2. Dual write to reg 3 and accumulator, then both-writes at index 0
    AccWrite   = 1'b1;
    RegWrite   = 1'b1;
    reg_index  = 4'd3;
    writeValue = 8'h5C;
    tick();
    AccWrite = 1'b0;
    RegWrite = 1'b0;
    model[0] = 8'h5C;
    model[3] = 8'h5C;
    check_val("dual_acc", 32'(acc_out), 32'h5C);
    push_all();
    drain("dual");

    AccWrite   = 1'b1;
    RegWrite   = 1'b1;
    reg_index  = 4'd0;
    writeValue = 8'h77;
    tick();
    AccWrite = 1'b0;
    RegWrite = 1'b0;
    model[0] = 8'h77;
    check_val("idx0_acc", 32'(acc_out), 32'h77);
    push_all();
    drain("idx0");

    // 3/4. Save with a dropped write during busy; check busy/done timing
    for (int i = 0; i < N; i++) write_reg(i, 8'(i * 3));
    for (int i = 0; i < N; i++) saved[i] = model[i];
    save_req = 1'b1;
    tick();
    save_req   = 1'b0;
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = -1;
    overlap    = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = cyc;
      end
      if (busy && done) overlap++;
      if (cyc == 2) begin
        RegWrite   = 1'b1;
        reg_index  = 4'd7;
        writeValue = 8'h11;
      end
      if (cyc == 3) RegWrite = 1'b0;
      tick();
    end
    check_val("save_busy_cycles", 32'(busy_cnt), 32'd16);
    check_val("save_done_cycles", 32'(done_cnt), 32'd1);
    check_val("save_done_at", 32'(first_done), 32'd16);
    check_val("save_busy_done_overlap", 32'(overlap), 32'd0);
    push_all();
    drain("busy_write");

    for (int i = 0; i < N; i++) write_reg(i, 8'hFF);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    check_val("restore_busy", 32'(busy), 32'd1);
    wait_done("restore");
    for (int i = 0; i < N; i++) model[i] = saved[i];
    push_all();
    drain("restore");

    // 5a. Reset in cycle 8 of SAVE discards the copy
    for (int i = 0; i < N; i++) write_reg(i, 8'(8'h40 + i));
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_val("midsave_busy", 32'(busy), 32'd1);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    clear_model();
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_done", 32'(done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check_val("midrst_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < N; i++) write_reg(i, 8'(8'h90 + i));
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_done("shadow_zero");
    clear_model();
    push_all();
    drain("shadow_zero");

    // 5b. Simultaneous requests: save must win
    for (int i = 0; i < N; i++) write_reg(i, 8'(i + 1));
    for (int i = 0; i < N; i++) saved[i] = model[i];
    save_req    = 1'b1;
    restore_req = 1'b1;
    tick();
    save_req    = 1'b0;
    restore_req = 1'b0;
    wait_done("prio_save");
    for (int i = 0; i < N; i++) write_reg(i, 8'hEE);
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    wait_done("prio_restore");
    for (int i = 0; i < N; i++) model[i] = saved[i];
    push_all();
    drain("prio");

    // 6. Bypass versus read-old-value on port B
    write_reg(2, 8'h11);
    RegWrite   = 1'b1;
    reg_index  = 4'd2;
    writeValue = 8'h3E;
    rd_index_b = 4'd2;
    #1;
    check_val("nobp_regb_old", 32'(regb_out), 32'h11);
    check_val("bp_regb_fwd", 32'(bp_regb_out), 32'h3E);
    check_val("bp_rega_fwd", 32'(bp_reg_out), 32'h3E);
    tick();
    RegWrite = 1'b0;
    model[2] = 8'h3E;
    check_val("nobp_regb_new", 32'(regb_out), 32'h3E);
    check_val("bp_regb_new", 32'(bp_regb_out), 32'h3E);
    AccWrite   = 1'b1;
    reg_index  = 4'd9;
    writeValue = 8'hC4;
    #1;
    check_val("bp_acc_fwd", 32'(bp_acc_out), 32'hC4);
    check_val("nobp_acc_old", 32'(acc_out), 32'(model[0]));
    tick();
    AccWrite = 1'b0;
    model[0] = 8'hC4;
    check_val("bp_busy_idle", 32'(bp_busy | bp_done), 32'd0);
    push_all();
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
